// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC and the
// {pc, instr} entry carried through the fetch skid buffer.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small skid FIFO of fetch entries with synchronous flush; flush wins over
// push and pop in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output logic                       full_o,
    output logic                       empty_o,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked by the owner while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational imem and queues
// {pc, instr} pairs toward decode; redirects reload the PC and flush the queue.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   redirect_target;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    // Stream to decode: a word transfers on a cycle where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and a
    // transfer coinciding with redirect_valid is dead on both sides.
    assign pop  = out_valid && out_ready;
    assign push = !redirect_valid && (!fifo_full || pop);

    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign wr_entry        = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_target;
        else if (push)      pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head),
        .count_o (fifo_count)
    );

    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign out_instr = fifo_empty ? NOP_INSTR : head.instr;
    assign out_pc    = fifo_empty ? RESET_PC  : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, full+pop,
// redirects (including PC wrap and back-to-back) and async reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    int checks;
    int failures;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    // Memory holds 0x100 + i at byte address 4i.
    assign imem_instr = 32'h0000_0100 + {2'b00, imem_addr[31:2]};

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, exp_pc);
        check({tag, "_instr"}, out_instr, exp_instr);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        step();
        step();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0000_0013);
        check("rst_pc", out_pc, 32'h0);
        rst_n = 1'b1;

        // Streaming at one word per cycle
        for (int i = 0; i < 6; i++) begin
            step();
            check_head($sformatf("stream%0d", i), 32'(4 * i), 32'(32'h100 + i));
        end

        // Asynchronous reset mid-stream, checked before any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'b0, out_valid}, 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_instr", out_instr, 32'h0000_0013);
        step();
        out_ready = 1'b0;
        rst_n     = 1'b1;

        // Backpressure from reset: fill to depth, PC freezes at 8
        step();
        check_head("bp_first", 32'h0, 32'h100);
        check("bp_cnt1", 32'(dut.fifo_count), 32'd1);
        check("bp_addr1", imem_addr, 32'h4);
        for (int i = 0; i < 4; i++) step();
        check("bp_cnt_full", 32'(dut.fifo_count), 32'd2);
        check("bp_addr_frozen", imem_addr, 32'h8);
        check_head("bp_head", 32'h0, 32'h100);

        // Release: full with pop keeps count constant and stream sequential
        out_ready = 1'b1;
        step();
        check_head("fp0", 32'h4, 32'h101);
        check("fp0_cnt", 32'(dut.fifo_count), 32'd2);
        check("fp0_addr", imem_addr, 32'hC);
        step();
        check_head("fp1", 32'h8, 32'h102);
        check("fp1_cnt", 32'(dut.fifo_count), 32'd2);
        step();
        check_head("fp2", 32'hC, 32'h103);

        // Redirect with a full buffer and a pop in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", {31'b0, out_valid}, 32'd0);
        check("rd_addr", imem_addr, 32'h200);
        check("rd_cnt", 32'(dut.fifo_count), 32'd0);
        step();
        check_head("rd_first", 32'h200, 32'h180);
        step();
        check_head("rd_second", 32'h204, 32'h181);

        // Redirect to the top word: PC wraps to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_valid", {31'b0, out_valid}, 32'd0);
        step();
        check_head("wrap_top", 32'hFFFF_FFFC, 32'h4000_00FF);
        step();
        check_head("wrap_zero", 32'h0, 32'h100);

        // Back-to-back redirects: last wins, nothing fetched from 0x40
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_pc    = 32'h0000_0080;
        check("dbl_addr1", imem_addr, 32'h40);
        check("dbl_valid1", {31'b0, out_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        check("dbl_addr2", imem_addr, 32'h80);
        check("dbl_valid2", {31'b0, out_valid}, 32'd0);
        step();
        check_head("dbl_first", 32'h80, 32'h120);
        step();
        check_head("dbl_second", 32'h84, 32'h121);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
